// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - default frame constants and the enable bundle shared by the I2S codec interface
package codec_pkg;

  localparam int DEF_SAMPLE_W      = 16;
  localparam int DEF_BITS_PER_SLOT = 32;
  localparam int DEF_CLKS_PER_BCLK = 4;

  localparam int FRAME_CLKS = 2 * DEF_BITS_PER_SLOT * DEF_CLKS_PER_BCLK;
  localparam int H          = FRAME_CLKS / 2;
  localparam int E          = DEF_SAMPLE_W * DEF_CLKS_PER_BCLK + DEF_CLKS_PER_BCLK / 2 + 1;
  localparam int REQ_OFFSET = 4;
  localparam int CNT_W      = $clog2(FRAME_CLKS);

  typedef struct packed {
    logic load_l;
    logic load_r;
    logic dac_edge;
    logic in_slot;
    logic right;
    logic adc_sample;
    logic end_l;
    logic end_r;
  } frame_en_t;

  function automatic int frame_clks(input int bits_per_slot, input int clks_per_bclk);
    return 2 * bits_per_slot * clks_per_bclk;
  endfunction

  function automatic int end_offset(input int sample_w, input int clks_per_bclk);
    return sample_w * clks_per_bclk + clks_per_bclk / 2 + 1;
  endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// rtl/i2s_frame_timer.sv - frame counter producing BCLK, LRCK, request/end strobes and shift-path enables
module i2s_frame_timer
  import codec_pkg::*;
#(
  parameter int SAMPLE_W      = DEF_SAMPLE_W,
  parameter int BITS_PER_SLOT = DEF_BITS_PER_SLOT,
  parameter int CLKS_PER_BCLK = DEF_CLKS_PER_BCLK
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       bclk_o,
  output logic       lrck_o,
  output logic [1:0] sample_end_o,
  output logic [1:0] sample_req_o,
  output frame_en_t  en_o
);

  localparam int FRAME_N = frame_clks(BITS_PER_SLOT, CLKS_PER_BCLK);
  localparam int HALF_N  = FRAME_N / 2;
  localparam int END_N   = end_offset(SAMPLE_W, CLKS_PER_BCLK);
  localparam int CW      = $clog2(FRAME_N);

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_LAST  = CW'(FRAME_N - 1);
  localparam logic [CW-1:0] C_HALF  = CW'(HALF_N);
  localparam logic [CW-1:0] C_END_L = CW'(END_N);
  localparam logic [CW-1:0] C_END_R = CW'(HALF_N + END_N);
  localparam logic [CW-1:0] C_REQ_L = CW'(FRAME_N - REQ_OFFSET);
  localparam logic [CW-1:0] C_REQ_R = CW'(HALF_N - REQ_OFFSET);
  localparam logic [CW-1:0] C_CPB   = CW'(CLKS_PER_BCLK);
  localparam logic [CW-1:0] C_BPS   = CW'(BITS_PER_SLOT);
  localparam logic [CW-1:0] C_RISE  = CW'(CLKS_PER_BCLK / 2);
  localparam logic [CW-1:0] C_SW    = CW'(SAMPLE_W);

  logic [CW-1:0] cnt_q, cnt_d, phase_d, bit_d, slot_d;
  logic          in_word_d, right_d;
  logic          bclk_q, lrck_q;
  logic [1:0]    sample_end_q, sample_req_q;

  // Every registered output is decoded from the count it will accompany.
  always_comb begin
    cnt_d     = (cnt_q == C_LAST) ? '0 : cnt_q + C_ONE;
    phase_d   = cnt_d % C_CPB;
    bit_d     = cnt_d / C_CPB;
    slot_d    = bit_d % C_BPS;
    in_word_d = (slot_d != '0) && (slot_d <= C_SW);
    right_d   = (cnt_d >= C_HALF);

    en_o            = '0;
    en_o.load_l     = (cnt_q == '0);
    en_o.load_r     = (cnt_q == C_HALF);
    en_o.dac_edge   = (phase_d == '0);
    en_o.in_slot    = in_word_d;
    en_o.right      = right_d;
    en_o.adc_sample = (phase_d == C_RISE) && in_word_d;
    en_o.end_l      = (cnt_d == C_END_L);
    en_o.end_r      = (cnt_d == C_END_R);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      sample_end_q <= 2'b00;
      sample_req_q <= 2'b00;
    end else begin
      cnt_q        <= cnt_d;
      bclk_q       <= (phase_d >= C_RISE);
      lrck_q       <= right_d;
      sample_end_q <= {cnt_d == C_END_L, cnt_d == C_END_R};
      sample_req_q <= {cnt_d == C_REQ_L, cnt_d == C_REQ_R};
    end
  end

  assign bclk_o       = bclk_q;
  assign lrck_o       = lrck_q;
  assign sample_end_o = sample_end_q;
  assign sample_req_o = sample_req_q;

endmodule

// File: rtl/audio_codec_if.sv
// rtl/audio_codec_if.sv - WM8731 I2S master with DAC serialiser and ADC capture; CODEC_LOOPBACK_EN feeds DAC data into the ADC path
module audio_codec_if
  import codec_pkg::*;
#(
  parameter int SAMPLE_W      = DEF_SAMPLE_W,
  parameter int BITS_PER_SLOT = DEF_BITS_PER_SLOT,
  parameter int CLKS_PER_BCLK = DEF_CLKS_PER_BCLK
) (
  input  logic                aud_clk,
  input  logic                aud_reset_n,
  output logic                aud_bclk,
  output logic                aud_lrck,
  input  logic                aud_adcdat,
  output logic                aud_dacdat,
  output logic [SAMPLE_W-1:0] audio_input_l,
  output logic [SAMPLE_W-1:0] audio_input_r,
  input  logic [SAMPLE_W-1:0] audio_output_l,
  input  logic [SAMPLE_W-1:0] audio_output_r,
  output logic [1:0]          sample_end,
  output logic [1:0]          sample_req
);

  frame_en_t           en;
  logic [SAMPLE_W-1:0] dac_l_q, dac_r_q, adc_sr_q, in_l_q, in_r_q;
  logic                dacdat_q, adc_bit;

  i2s_frame_timer #(
    .SAMPLE_W      (SAMPLE_W),
    .BITS_PER_SLOT (BITS_PER_SLOT),
    .CLKS_PER_BCLK (CLKS_PER_BCLK)
  ) u_timer (
    .clk_i        (aud_clk),
    .rst_ni       (aud_reset_n),
    .bclk_o       (aud_bclk),
    .lrck_o       (aud_lrck),
    .sample_end_o (sample_end),
    .sample_req_o (sample_req),
    .en_o         (en)
  );

`ifdef CODEC_LOOPBACK_EN
  logic unused_adcdat;
  assign unused_adcdat = aud_adcdat;
  assign adc_bit       = dacdat_q;
`else
  assign adc_bit = aud_adcdat;
`endif

  always_ff @(posedge aud_clk) begin
    if (!aud_reset_n) begin
      dac_l_q  <= '0;
      dac_r_q  <= '0;
      adc_sr_q <= '0;
      in_l_q   <= '0;
      in_r_q   <= '0;
      dacdat_q <= 1'b0;
    end else begin
      if (en.load_l) dac_l_q <= audio_output_l;
      if (en.load_r) dac_r_q <= audio_output_r;
      // DAC data only moves on BCLK falls; slot bits outside the word read as 0.
      if (en.dac_edge) begin
        if (!en.in_slot) begin
          dacdat_q <= 1'b0;
        end else if (en.right) begin
          dacdat_q <= dac_r_q[SAMPLE_W-1];
          dac_r_q  <= dac_r_q << 1;
        end else begin
          dacdat_q <= dac_l_q[SAMPLE_W-1];
          dac_l_q  <= dac_l_q << 1;
        end
      end
      if (en.adc_sample) adc_sr_q <= {adc_sr_q[SAMPLE_W-2:0], adc_bit};
      if (en.end_l)      in_l_q   <= adc_sr_q;
      if (en.end_r)      in_r_q   <= adc_sr_q;
    end
  end

  assign aud_dacdat    = dacdat_q;
  assign audio_input_l = in_l_q;
  assign audio_input_r = in_r_q;

endmodule

// File: tb/tb_audio_codec_if.sv
// tb/tb_audio_codec_if.sv - self-checking bench for audio_codec_if against a frame-position reference model
module tb_audio_codec_if;

  localparam int SW = 16;
  localparam int FR = 256;
  localparam int HF = FR / 2;
  localparam int EE = 67;
  localparam int RQ = 4;

  logic          aud_clk        = 1'b0;
  logic          aud_reset_n    = 1'b0;
  logic          aud_adcdat     = 1'b0;
  logic [SW-1:0] audio_output_l = '0;
  logic [SW-1:0] audio_output_r = '0;
  logic          aud_bclk, aud_lrck, aud_dacdat;
  logic [SW-1:0] audio_input_l, audio_input_r;
  logic [1:0]    sample_end, sample_req;

  audio_codec_if dut (
    .aud_clk        (aud_clk),
    .aud_reset_n    (aud_reset_n),
    .aud_bclk       (aud_bclk),
    .aud_lrck       (aud_lrck),
    .aud_adcdat     (aud_adcdat),
    .aud_dacdat     (aud_dacdat),
    .audio_input_l  (audio_input_l),
    .audio_input_r  (audio_input_r),
    .audio_output_l (audio_output_l),
    .audio_output_r (audio_output_r),
    .sample_end     (sample_end),
    .sample_req     (sample_req)
  );

  always #5 aud_clk = ~aud_clk;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;
  int n_end_l, n_end_r, n_req_l, n_req_r;

  logic [SW-1:0] dac_w_l  = '0, dac_w_r  = '0;
  logic [SW-1:0] adc_w_l  = '0, adc_w_r  = '0;
  logic [SW-1:0] exp_in_l = '0, exp_in_r = '0;
  logic [SW-1:0] plan_dac_l[$];
  logic [SW-1:0] plan_dac_r[$];
  logic [SW-1:0] plan_adc_l[$];
  logic [SW-1:0] plan_adc_r[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle();
    check("rst_bclk",    32'(aud_bclk),      32'd0);
    check("rst_lrck",    32'(aud_lrck),      32'd0);
    check("rst_dacdat",  32'(aud_dacdat),    32'd0);
    check("rst_input_l", 32'(audio_input_l), 32'd0);
    check("rst_input_r", 32'(audio_input_r), 32'd0);
    check("rst_end",     32'(sample_end),    32'd0);
    check("rst_req",     32'(sample_req),    32'd0);
  endtask

  function automatic logic [SW-1:0] next_word(inout logic [SW-1:0] plan[$]);
    if (plan.size() > 0) return plan.pop_front();
    return SW'($urandom);
  endfunction

  // One aud_clk cycle at frame position pos: check outputs, then drive inputs.
  task automatic body();
    int            p, s;
    bit            half, in_word;
    logic [SW-1:0] w, a;
    logic          exp_dac;
    logic [1:0]    exp_end, exp_req;

    p       = pos % 4;
    s       = (pos / 4) % 32;
    half    = (pos >= HF);
    in_word = (s >= 1) && (s <= SW);

    if (pos == 0)  adc_w_l = next_word(plan_adc_l);
    if (pos == HF) adc_w_r = next_word(plan_adc_r);

    w       = half ? dac_w_r : dac_w_l;
    exp_dac = in_word ? w[SW-s] : 1'b0;
    exp_end = (pos == EE) ? 2'b10 : (pos == HF + EE) ? 2'b01 : 2'b00;
    exp_req = (pos == FR - RQ) ? 2'b10 : (pos == HF - RQ) ? 2'b01 : 2'b00;
`ifdef CODEC_LOOPBACK_EN
    if (pos == EE)      exp_in_l = dac_w_l;
    if (pos == HF + EE) exp_in_r = dac_w_r;
`else
    if (pos == EE)      exp_in_l = adc_w_l;
    if (pos == HF + EE) exp_in_r = adc_w_r;
`endif

    check("bclk",    32'(aud_bclk),      32'(p >= 2));
    check("lrck",    32'(aud_lrck),      32'(half));
    check("dacdat",  32'(aud_dacdat),    32'(exp_dac));
    check("end",     32'(sample_end),    32'(exp_end));
    check("req",     32'(sample_req),    32'(exp_req));
    check("input_l", 32'(audio_input_l), 32'(exp_in_l));
    check("input_r", 32'(audio_input_r), 32'(exp_in_r));
    check("strobe_onehot", 32'($countones({sample_end, sample_req}) <= 1), 32'd1);

    n_end_l += int'(sample_end[1]);
    n_end_r += int'(sample_end[0]);
    n_req_l += int'(sample_req[1]);
    n_req_r += int'(sample_req[0]);

    a          = half ? adc_w_r : adc_w_l;
    aud_adcdat = in_word ? a[SW-s] : 1'($urandom);

    // New DAC words arrive on request and are scrambled right after the load.
    if (pos == 1)       audio_output_l = SW'($urandom);
    if (pos == HF + 1)  audio_output_r = SW'($urandom);
    if (pos == FR - RQ) audio_output_l = next_word(plan_dac_l);
    if (pos == HF - RQ) audio_output_r = next_word(plan_dac_r);
    if (pos == 0)       dac_w_l = audio_output_l;
    if (pos == HF)      dac_w_r = audio_output_r;

    pos = (pos + 1) % FR;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge aud_clk);
      body();
    end
  endtask

  task automatic hold_reset(input int n);
    aud_reset_n = 1'b0;
    repeat (n) begin
      @(negedge aud_clk);
      check_idle();
    end
  endtask

  task automatic release_reset();
    aud_reset_n = 1'b1;
    pos         = 0;
    exp_in_l    = '0;
    exp_in_r    = '0;
    body();
  endtask

  initial begin
    plan_dac_l = '{16'hA5C3, 16'h1234};
    plan_dac_r = '{16'h0001};
    plan_adc_l = '{16'h8001};
    plan_adc_r = '{16'h7FFE};
    audio_output_l = next_word(plan_dac_l);
    audio_output_r = SW'($urandom);

    hold_reset(10);
    n_end_l = 0; n_end_r = 0; n_req_l = 0; n_req_r = 0;
    release_reset();
    run(4 * FR - 1);
    check("cadence_end_l", 32'(n_end_l), 32'd4);
    check("cadence_end_r", 32'(n_end_r), 32'd4);
    check("cadence_req_l", 32'(n_req_l), 32'd4);
    check("cadence_req_r", 32'(n_req_r), 32'd4);

    run(41);
    hold_reset(3);
    release_reset();
    run(2 * FR - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
